fir_out_decimator: RTL and testbench

//  Downstream stage of fir_filter. Takes the wide signed FIR result every clock, keeps 1 of

---
 rtl/fir_pkg.sv | 41 ++++
 rtl/fir_out_fifo.sv | 53 +++++
 rtl/fir_out_decimator.sv | 94 +++++++++
 tb/tb_fir_out_decimator.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR output widths, saturation limits and round/shift/saturate helper
package fir_pkg;

    localparam int DEF_IN_WIDTH  = 20;
    localparam int DEF_OUT_WIDTH = 16;

    localparam logic signed [DEF_OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_OUT_WIDTH-1){1'b1}}};
    localparam logic signed [DEF_OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_OUT_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } rss_t;

    // Round half up, arithmetic shift, clip to a signed out_w-bit range; works on a 64-bit
    // sign-extended value so any caller width up to 62 bits fits with headroom.
    function automatic rss_t round_shift_sat(input logic signed [63:0] x,
                                             input int shift,
                                             input int out_w);
        logic signed [63:0] rnd;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rss_t               res;
        rnd = (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
        r   = (x + rnd) >>> shift;
        hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (out_w - 1));
        res.sat = 1'b1;
        if (r > hi) begin
            res.val = hi;
        end else if (r < lo) begin
            res.val = lo;
        end else begin
            res.val = r;
            res.sat = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// rtl/fir_out_fifo.sv - first-word fall-through FIFO with occupancy count
module fir_out_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_rd;
    logic             do_wr;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_rd    = rd_en_i && !empty_o;
        do_wr    = wr_en_i && (!full_o || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fir_out_decimator.sv
// rtl/fir_out_decimator.sv - decimate, round/shift/saturate and queue FIR output samples
module fir_out_decimator
    import fir_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int SHIFT     = 2,
    parameter int DECIM     = 2,
    parameter int DEPTH     = 4,
    parameter int AW        = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  y_in,
    input  logic                 in_valid,
    input  logic                 clr_flags,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AW:0]          count,
    output logic                 sat_flag,
    output logic                 ovf_flag
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PW-1:0]        phase_q, phase_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [OUT_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                 sat_q, sat_d;
    logic                 ovf_q, ovf_d;
    logic                 keep;
    logic                 rd_fire;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic signed [63:0]   y_ext;
    rss_t                 rs;
    logic                 unused_rs_hi;

    assign y_ext        = {{(64-IN_WIDTH){y_in[IN_WIDTH-1]}}, y_in};
    assign unused_rs_hi = ^rs.val[63:OUT_WIDTH];

    always_comb begin
        keep       = in_valid && (phase_q == '0);
        rd_fire    = out_valid && out_ready;
        rs         = round_shift_sat(y_ext, SHIFT, OUT_WIDTH);
        phase_d    = phase_q;
        if (in_valid) begin
            phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
        end
        s1_valid_d = keep;
        s1_data_d  = rs.val[OUT_WIDTH-1:0];
        // A new event in the same cycle as a clear leaves the flag set.
        sat_d      = (sat_q && !clr_flags) || (keep && rs.sat);
        ovf_d      = (ovf_q && !clr_flags) || (s1_valid_q && fifo_full && !rd_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
        end
    end

    fir_out_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (s1_valid_q),
        .wr_data_i (s1_data_q),
        .rd_en_i   (out_ready),
        .rd_data_o (out_data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (count)
    );

    assign out_valid = !fifo_empty;
    assign sat_flag  = sat_q;
    assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// tb/tb_fir_out_decimator.sv - directed self-checking bench for fir_out_decimator
module tb_fir_out_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] y_a, y_b;
    logic        v_a, v_b, clr_a, clr_b, rdy_a, rdy_b;
    logic [15:0] od_a, od_b;
    logic        ov_a, ov_b;
    logic [2:0]  cnt_a, cnt_b;
    logic        sat_a, sat_b, ovf_a, ovf_b;
    int          n_run  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fir_out_decimator #(.IN_WIDTH(20), .OUT_WIDTH(16), .SHIFT(2), .DECIM(2), .DEPTH(4), .AW(2)) dut_a (
        .clk(clk), .rst(rst), .y_in(y_a), .in_valid(v_a), .clr_flags(clr_a),
        .out_data(od_a), .out_valid(ov_a), .out_ready(rdy_a), .count(cnt_a),
        .sat_flag(sat_a), .ovf_flag(ovf_a)
    );

    fir_out_decimator #(.IN_WIDTH(20), .OUT_WIDTH(16), .SHIFT(2), .DECIM(1), .DEPTH(4), .AW(2)) dut_b (
        .clk(clk), .rst(rst), .y_in(y_b), .in_valid(v_b), .clr_flags(clr_b),
        .out_data(od_b), .out_valid(ov_b), .out_ready(rdy_b), .count(cnt_b),
        .sat_flag(sat_b), .ovf_flag(ovf_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_run++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int sx(input logic [15:0] d);
        return int'($signed(d));
    endfunction

    // One kept sample (phase 0) followed by one dropped sample; kept value lands in the FIFO.
    task automatic feed_pair(input int val);
        y_a = 20'(val);
        v_a = 1'b1;
        tick();
        y_a = 20'd999;
        tick();
        v_a = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        y_a = '0; y_b = '0; v_a = 0; v_b = 0;
        clr_a = 0; clr_b = 0; rdy_a = 0; rdy_b = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst_valid_a", int'(ov_a), 0);
        check("rst_count_a", int'(cnt_a), 0);
        check("rst_data_a", sx(od_a), 0);
        check("rst_sat_a", int'(sat_a), 0);
        check("rst_ovf_a", int'(ovf_a), 0);
        check("rst_valid_b", int'(ov_b), 0);

        // decimate by 2: 40,80,120,160 -> 10,30
        rdy_a = 1'b1;
        y_a = 20'd40;  v_a = 1'b1; tick();
        check("dec_lat_not_yet", int'(ov_a), 0);
        y_a = 20'd80;  tick();
        check("dec_first_valid", int'(ov_a), 1);
        check("dec_first_data", sx(od_a), 10);
        y_a = 20'd120; tick();
        check("dec_80_dropped", int'(ov_a), 0);
        y_a = 20'd160; tick();
        check("dec_second_data", sx(od_a), 30);
        v_a = 1'b0; tick();
        check("dec_160_dropped", int'(ov_a), 0);
        tick();
        check("dec_empty_count", int'(cnt_a), 0);
        rdy_a = 1'b0;

        // no decimation, rounding of small negatives/positives
        rdy_b = 1'b1;
        y_b = 20'(-6); v_b = 1'b1; tick();
        y_b = 20'(-7); tick();
        check("rnd_m6", sx(od_b), -1);
        y_b = 20'(5);  tick();
        check("rnd_m7", sx(od_b), -2);
        y_b = 20'(6);  tick();
        check("rnd_p5", sx(od_b), 1);
        v_b = 1'b0; tick();
        check("rnd_p6", sx(od_b), 2);
        tick();
        check("rnd_drained", int'(ov_b), 0);
        check("rnd_no_sat", int'(sat_b), 0);

        // saturation both rails, flag clear, event beats clear
        y_b = 20'd262143; v_b = 1'b1; tick();
        check("sat_flag_set", int'(sat_b), 1);
        y_b = 20'(-524288); tick();
        check("sat_max", sx(od_b), 32767);
        v_b = 1'b0; tick();
        check("sat_min", sx(od_b), -32768);
        clr_b = 1'b1; tick();
        clr_b = 1'b0;
        check("sat_cleared", int'(sat_b), 0);
        clr_b = 1'b1; y_b = 20'd262143; v_b = 1'b1; tick();
        clr_b = 1'b0; v_b = 1'b0;
        check("sat_event_wins", int'(sat_b), 1);
        tick(); tick();
        check("sat_drained", int'(ov_b), 0);
        check("sat_no_ovf", int'(ovf_b), 0);

        // overflow: five kept samples into a 4-deep FIFO
        for (int k = 1; k <= 4; k++) feed_pair(k * 16);
        check("ovf_fill_count", int'(cnt_a), 4);
        check("ovf_not_yet", int'(ovf_a), 0);
        feed_pair(80);
        check("ovf_count_held", int'(cnt_a), 4);
        check("ovf_flag_set", int'(ovf_a), 1);
        rdy_a = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_%0d", i), sx(od_a), 4 * i);
            tick();
        end
        rdy_a = 1'b0;
        check("drain_empty", int'(cnt_a), 0);
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        check("ovf_cleared", int'(ovf_a), 0);

        // full + write + read in the same cycle
        for (int k = 6; k <= 9; k++) feed_pair(k * 16);
        check("refill_count", int'(cnt_a), 4);
        y_a = 20'd160; v_a = 1'b1; tick();
        y_a = 20'd999; rdy_a = 1'b1; tick();
        v_a = 1'b0; rdy_a = 1'b0;
        check("rw_count", int'(cnt_a), 4);
        check("rw_no_ovf", int'(ovf_a), 0);
        check("rw_head", sx(od_a), 28);
        tick();
        check("hold_head", sx(od_a), 28);
        rdy_a = 1'b1; tick(); tick(); rdy_a = 1'b0;
        check("pre_rst_count", int'(cnt_a), 2);
        check("pre_rst_head", sx(od_a), 36);

        // reset mid-stream with phase left at 1
        y_a = 20'd48; v_a = 1'b1; tick();
        v_a = 1'b0; tick();
        check("mid_count3", int'(cnt_a), 3);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mid_rst_count", int'(cnt_a), 0);
        check("mid_rst_valid", int'(ov_a), 0);
        check("mid_rst_data", sx(od_a), 0);
        y_a = 20'd20; v_a = 1'b1; tick();
        y_a = 20'd100; tick();
        v_a = 1'b0;
        check("post_rst_count", int'(cnt_a), 1);
        check("post_rst_first_kept", sx(od_a), 5);
        rdy_a = 1'b1; tick(); rdy_a = 1'b0;
        check("post_rst_drained", int'(cnt_a), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
